instr_fetch: RTL and testbench

Instruction fetch unit producing the `Instruction` word consumed by the main control decoder. It holds the PC, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. Each buffered entry carries its PC and is presented to decode through a valid/ready handshake. A redirect input from execute covers taken branch, bne, or jump: it reloads the PC and squashes everything fetched down the old path.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants, opcodes and fetch entry type
package mips_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Primary opcodes recognised by the main control decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // One fetch-buffer entry: the word together with the address it came from
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and head read
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; flush empties the FIFO regardless of push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents of empty slots are never observed, so no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, instruction memory request issue, response buffering and redirect
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] discard;
    logic [CW:0]   in_use;
    logic          pcq_empty;
    logic [31:0]   pcq_head;
    logic          fb_empty;
    fetch_entry_t  fb_in;
    fetch_entry_t  fb_head;
    logic          req_fire;
    logic          rsp_fire;
    logic          fb_push;
    logic          fb_pop;
    logic          unused_redirect_bits;

    // Low address bits of a redirect target are ignored by design
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Every word either in flight or buffered holds a buffer slot, so the buffer can never overflow
    assign in_use         = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = rst_n && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are stray and ignored
    assign rsp_fire = imem_rsp_valid && !pcq_empty;
    assign fb_push  = rsp_fire && (discard == '0) && !redirect_valid;
    assign fb_pop   = instr_valid && instr_ready;
    assign fb_in    = '{pc: pcq_head, instr: imem_rsp_data};

    assign instr_valid = !fb_empty;
    assign instruction = instr_valid ? fb_head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? fb_head.pc    : 32'h0000_0000;

    // PC of every accepted request, popped in order as responses return
    fetch_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_fire),
        .flush     (1'b0),
        .head      (pcq_head),
        .count     (outstanding),
        .empty     (pcq_empty)
    );

    // Fetched words waiting for decode, each tagged with its PC
    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fb_push),
        .push_data (fb_in),
        .pop       (fb_pop),
        .flush     (redirect_valid),
        .head      (fb_head),
        .count     (buf_count),
        .empty     (fb_empty)
    );

    // Fetch address: reload on redirect, otherwise advance one word per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    // Count of in-flight responses belonging to a squashed path; everything in flight at a redirect is stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard <= '0;
        end else if (redirect_valid) begin
            discard <= outstanding - CW'(rsp_fire);
        end else if (rsp_fire && (discard != '0)) begin
            discard <= discard - CW'(1);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch with memory and stream model
module tb_instr_fetch;
    import mips_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] cons_q[$];
    int          cyc;
    int          k = 1;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_con = 0;
    int          n_req = 0;
    logic [31:0] exp_req;
    logic [31:0] exp_con;
    logic        prev_redir = 1'b0;

    logic        s_req_valid, s_req_fire, s_instr_valid, s_consume, s_rsp, s_redir;
    logic [31:0] s_req_addr, s_instr, s_instr_pc, s_target;

    // Memory image: an opcode from the decoder's set plus address-hashed payload
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] h;
        logic [5:0]  op;
        h = a * 32'h9E37_79B1 + 32'h1234_5678;
        case (a[4:2])
            3'd0: op = OP_RTYPE;
            3'd1: op = OP_LW;
            3'd2: op = OP_SW;
            3'd3: op = OP_BEQ;
            3'd4: op = OP_BNE;
            3'd5: op = OP_ADDI;
            3'd6: op = OP_J;
            default: op = OP_JAL;
        endcase
        return {op, h[31:6]};
    endfunction

    // One clock: sample on negedge, check against the instruction-stream model, then advance memory
    task automatic tick();
        @(negedge clk);
        s_req_valid   = imem_req_valid;
        s_req_addr    = imem_req_addr;
        s_req_fire    = imem_req_valid && imem_req_ready;
        s_instr_valid = instr_valid;
        s_instr       = instruction;
        s_instr_pc    = instr_pc;
        s_consume     = instr_valid && instr_ready;
        s_rsp         = imem_rsp_valid;
        s_redir       = redirect_valid;
        s_target      = {redirect_pc[31:2], 2'b00};
        if (rst_n) begin
            if (prev_redir) begin
                n_cmp++;
                if (s_instr_valid !== 1'b0) begin
                    n_fail++; $display("FAIL valid_after_redirect got %b want 0", s_instr_valid);
                end
            end
            if (s_redir) begin
                n_cmp++;
                if (s_req_valid !== 1'b0) begin
                    n_fail++; $display("FAIL req_in_redirect_cycle got %b want 0", s_req_valid);
                end
            end
            if (s_req_fire) begin
                n_cmp++;
                if (s_req_addr !== exp_req) begin
                    n_fail++; $display("FAIL req_addr got %h want %h", s_req_addr, exp_req);
                end
                exp_req = exp_req + 32'd4;
                n_req++;
            end
            if (s_consume) begin
                n_cmp++;
                if (s_instr_pc !== exp_con) begin
                    n_fail++; $display("FAIL instr_pc got %h want %h", s_instr_pc, exp_con);
                end
                n_cmp++;
                if (s_instr !== memf(exp_con)) begin
                    n_fail++; $display("FAIL instruction at %h got %h want %h", exp_con, s_instr, memf(exp_con));
                end
                cons_q.push_back(s_instr_pc);
                exp_con = exp_con + 32'd4;
                n_con++;
            end
            if (s_redir) begin
                exp_req = s_target;
                exp_con = s_target;
            end
        end
        prev_redir = s_redir && rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rsp) void'(mem_q.pop_front());
        if (s_req_fire) mem_q.push_back('{addr: s_req_addr, due: cyc + k - 1});
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic start_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_q.delete();
        cons_q.delete();
        prev_redir = 1'b0;
        exp_req    = RST_PC;
        exp_con    = RST_PC;
        k          = 1;
        repeat (2) tick();
    endtask

    task automatic do_reset();
        start_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start_reset();
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        n_cmp++;
        if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL reset_req_addr got %h want %h", imem_req_addr, RST_PC); end
        n_cmp++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
        n_cmp++;
        if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instruction got %h want 0", instruction); end
        n_cmp++;
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got %h want 0", instr_pc); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got %b want 1", imem_req_valid); end
    endtask

    task automatic test_stream();
        int first_req, first_val, nval, c0;
        do_reset();
        k = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        first_req = -1; first_val = -1; nval = 0; c0 = n_con;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_req_fire && first_req < 0) first_req = i;
            if (s_instr_valid) begin
                if (first_val < 0) first_val = i;
                nval++;
            end
        end
        n_cmp++;
        if (first_req !== 0) begin n_fail++; $display("FAIL stream_first_req got %0d want 0", first_req); end
        n_cmp++;
        if (first_val - first_req !== 2) begin n_fail++; $display("FAIL stream_latency got %0d want 2", first_val - first_req); end
        n_cmp++;
        if (nval !== 18) begin n_fail++; $display("FAIL stream_throughput got %0d want 18", nval); end
        n_cmp++;
        if (n_con - c0 !== 18) begin n_fail++; $display("FAIL stream_consumed got %0d want 18", n_con - c0); end
    endtask

    task automatic test_backpressure();
        int r0;
        logic [31:0] want;
        do_reset();
        k = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        r0 = n_req;
        repeat (10) tick();
        n_cmp++;
        if (n_req - r0 !== DEPTH) begin n_fail++; $display("FAIL bp_req_count got %0d want %0d", n_req - r0, DEPTH); end
        n_cmp++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_stalled got %b want 0", s_req_valid); end
        n_cmp++;
        if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL bp_head got %b/%h want 1/00000000", s_instr_valid, s_instr_pc);
        end
        instr_ready = 1'b1;
        cons_q.delete();
        repeat (6) tick();
        n_cmp++;
        if (cons_q.size() < 4) begin
            n_fail++; $display("FAIL bp_release_count got %0d want >=4", cons_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                want = 32'(4 * i);
                n_cmp++;
                if (cons_q[i] !== want) begin n_fail++; $display("FAIL bp_release_pc[%0d] got %h want %h", i, cons_q[i], want); end
            end
        end
    endtask

    task automatic test_redirect_drop();
        int t;
        do_reset();
        k = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (3) tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        cons_q.delete();
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_first_req got %b/%h want 1/00000100", s_req_valid, s_req_addr);
        end
        t = 0;
        while (cons_q.size() == 0 && t < 30) begin tick(); t++; end
        n_cmp++;
        if (cons_q.size() == 0) begin
            n_fail++; $display("FAIL redir_timeout got 0 consumed want 1");
        end else if (cons_q[0] !== 32'h100 || s_instr !== memf(32'h100)) begin
            n_fail++; $display("FAIL redir_target got %h/%h want 00000100/%h", cons_q[0], s_instr, memf(32'h100));
        end
    endtask

    task automatic test_redirect_same_cycle();
        int c0, t;
        do_reset();
        k = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (2) tick();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        c0 = n_con;
        tick();
        n_cmp++;
        if (n_con - c0 !== 1 || s_instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL same_cycle_consume got %0d/%h want 1/00000000", n_con - c0, s_instr_pc);
        end
        redirect_valid = 1'b0;
        cons_q.delete();
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h40) begin
            n_fail++; $display("FAIL same_cycle_next_addr got %b/%h want 1/00000040", s_req_valid, s_req_addr);
        end
        t = 0;
        while (cons_q.size() == 0 && t < 20) begin tick(); t++; end
        n_cmp++;
        if (cons_q.size() == 0 || cons_q[0] !== 32'h40) begin
            n_fail++; $display("FAIL same_cycle_dropped got %0d entries want head 00000040", cons_q.size());
        end
    endtask

    task automatic test_wrap();
        k = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        cons_q.delete();
        tick();
        n_cmp++;
        if (s_req_fire !== 1'b1 || s_req_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_first got %b/%h want 1/fffffffc", s_req_fire, s_req_addr);
        end
        tick();
        n_cmp++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next got %b/%h want 1/00000000", s_req_valid, s_req_addr);
        end
        repeat (6) tick();
        n_cmp++;
        if (cons_q.size() < 2 || cons_q[0] !== 32'hFFFF_FFFC || cons_q[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_consume got %0d entries want fffffffc then 00000000", cons_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int nbad;
        do_reset();
        k = 2; imem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL mid_precond got %b/%h want 1/00000000", instr_valid, instr_pc);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== RST_PC) begin
            n_fail++; $display("FAIL mid_req got %b/%h want 0/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        n_cmp++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL mid_instr got %b/%h/%h want 0/0/0", instr_valid, instruction, instr_pc);
        end
        imem_req_ready = 1'b0;
        exp_req = RST_PC; exp_con = RST_PC; prev_redir = 1'b0;
        tick();
        rst_n = 1'b1;
        nbad = 0;
        repeat (6) begin
            tick();
            if (s_instr_valid) nbad++;
        end
        n_cmp++;
        if (nbad !== 0) begin n_fail++; $display("FAIL mid_late_rsp got %0d valid cycles want 0", nbad); end
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        cons_q.delete();
        repeat (12) tick();
        n_cmp++;
        if (cons_q.size() == 0 || cons_q[0] !== RST_PC) begin
            n_fail++; $display("FAIL mid_restart got %0d entries want head %h", cons_q.size(), RST_PC);
        end
    endtask

    task automatic test_random();
        int c0;
        do_reset();
        c0 = n_con;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            k              = int'($urandom_range(1, 4));
            if (!redirect_valid && $urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom_range(0, 32'h3FF);
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        n_cmp++;
        if (n_con - c0 < 100) begin n_fail++; $display("FAIL random_progress got %0d want >=100", n_con - c0); end
    endtask

    initial begin
        cyc = 0;
        exp_req = RST_PC;
        exp_con = RST_PC;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
